oric_tape_player: RTL
=====================

Name: oric_tape_player

Overview:
- Tape playback source: the transmit-side counterpart of the Oric cassette input.
- Reads a downloaded .TAP image byte-by-byte from the SDRAM download buffer over a request/acknowledge port.
- Serialises each byte into Oric fast-format tape frames on a single output wire.
- The top level ORs this output into the oricatmos K7_TAPEIN path, so tapes load without an external audio source.

Parameters:
- HALF_SHORT, 5000: clk_24 cycles per short half-period (2400 Hz tone at 24 MHz).
- HALF_LONG, 10000: clk_24 cycles per long half-period, used by '0' bits.
- STOP_BITS, 4: number of '1' stop bits per frame, range 1-15.
- ADDR_W, 20: width of image address and length.

Ports:
- clk_24  in  1  system clock, 24 MHz.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins playback at address 0.
- stop  in  1  one-cycle pulse; aborts playback.
- tap_len  in  ADDR_W  image length in bytes; sampled on start.
- rd_req  out  1  buffer read request; level signal.
- rd_addr  out  ADDR_W  byte address; stable while rd_req=1.
- rd_ack  in  1  one-cycle pulse; rd_data is valid in the same cycle.
- rd_data  in  8  byte returned by the buffer.
- remote  in  1  cassette motor relay from the VIA (K7_REMOTE).
- tape_out  out  1  serial tape waveform.
- busy  out  1  high from accepted start until done or abort.
- done  out  1  one-cycle pulse after the last stop bit of the last byte.

Behaviour:
- Clocking: clk_24 is the clock; reset is synchronous, active-high.
- Reset values: tape_out=0, rd_req=0, rd_addr=0, busy=0, done=0. FSM enters IDLE and all counters clear.
- FSM states: IDLE, FETCH, SEND, FINISH.
- IDLE:
  - tape_out=0.
  - On start: latch tap_len and clear rd_addr.
  - If tap_len==0, go to FINISH.
  - Otherwise set busy=1 and go to FETCH.
  - start while busy=1 is ignored.
- FETCH:
  - Assert rd_req.
  - On rd_ack: load the shift register with the frame, drop rd_req in the next cycle, go to SEND.
  - rd_ack while rd_req=0 is ignored.
- Frame format, in transmit order:
  - start bit '0';
  - 8 data bits, LSB first;
  - parity bit = ~^data (odd parity, so total ones over data+parity is odd);
  - STOP_BITS bits of '1'.
  - Total frame length: 10+STOP_BITS bits.
- Bit cell:
  - Phase A: tape_out=1 for HALF_SHORT cycles.
  - Phase B: tape_out=0 for HALF_SHORT cycles ('1' bit) or HALF_LONG cycles ('0' bit).
  - Bit period is 2*HALF_SHORT for '1' and HALF_SHORT+HALF_LONG for '0'.
  - Cells are back-to-back with no gaps.
- Next byte:
  - After the last stop bit, rd_addr increments.
  - If rd_addr == tap_len-1 at that point, go to FINISH.
  - Otherwise go to FETCH; tape_out holds 0 while waiting for rd_ack.
- FINISH:
  - Pulse done for one cycle, clear busy, return to IDLE.
  - For the tap_len==0 case, done pulses 1 cycle after start.
- Abort:
  - stop in any state goes to IDLE next cycle with tape_out=0, rd_req=0, busy=0.
  - No done pulse is issued.
  - A pending rd_ack is discarded.
- Simultaneous events:
  - start and stop in the same cycle: stop wins.
  - reset mid-frame: identical to the reset values above.
- Widths: half-period counter is 16 bits (HALF_LONG <= 65535); bit counter is 4 bits.

Optional Feature:
- Macro: TAPE_REMOTE_GATE_EN.
- With the macro defined:
  - When remote=0, the phase counter freezes and tape_out holds its current level.
  - FETCH may still complete, but SEND does not advance.
  - Playback resumes exactly where it stopped when remote=1.
  - busy stays 1 while paused.
- Without the macro: remote is unused, and playback runs unconditionally.

Test Plan:
- HALF_SHORT=4, HALF_LONG=8, STOP_BITS=4; tap_len=1, byte 0x16.
  - Bit sequence: 0, 0,1,1,0,1,0,0,0, parity 0, 1,1,1,1.
  - Frame lasts exactly 140 cycles.
  - done pulses once; busy falls with it.
- Same parameters, byte 0x24: parity bit=1; frame lasts 12+(6*12+2*8)+8+32 = 140 cycles; tape_out waveform matches cycle by cycle.
- tap_len=3, rd_ack delayed 5 cycles per request:
  - rd_addr sequence 0,1,2, three frames;
  - tape_out=0 during each wait;
  - exactly one done.
- tap_len=0 -> no rd_req; done pulses 1 cycle after start; busy never asserts.
- stop during the 3rd data bit of byte 0 -> next cycle tape_out=0, busy=0, rd_req=0, no done; a following start replays from address 0.
- With TAPE_REMOTE_GATE_EN: drop remote for 50 cycles mid phase A -> tape_out stays 1 for the whole gap and the total frame lengthens by exactly 50 cycles. Without the macro, the frame length is unchanged.

Source files
------------

// File: rtl/oric_tape_player.sv
// Oric fast-format tape playback: fetches .TAP bytes over a req/ack port and serialises them onto tape_out.
// Optional feature macro TAPE_REMOTE_GATE_EN: the cassette motor relay (remote) pauses the bit-cell timer.
module oric_tape_player #(
  parameter int unsigned HALF_SHORT = 5000,
  parameter int unsigned HALF_LONG  = 10000,
  parameter int unsigned STOP_BITS  = 4,
  parameter int unsigned ADDR_W     = 20
) (
  input  logic              clk_24,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] tap_len,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [7:0]        rd_data,
  input  logic              remote,
  output logic              tape_out,
  output logic              busy,
  output logic              done
);
  localparam int unsigned CNT_W = 16;
  localparam int unsigned BIT_W = 4;
  localparam int unsigned SHR_W = 10;
  localparam logic [CNT_W-1:0] SHORT_END = CNT_W'(HALF_SHORT - 1);
  localparam logic [CNT_W-1:0] LONG_END  = CNT_W'(HALF_LONG - 1);
  localparam logic [BIT_W-1:0] LAST_BODY = BIT_W'(SHR_W - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, FINISH} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                req_d, tape_d, busy_d, done_d;
  logic [SHR_W-1:0]    shr_q, shr_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                phase_b_q, phase_b_d;
  logic                in_stop_q, in_stop_d;
  logic                run;
  logic                cur_bit;
  logic [CNT_W-1:0]    b_end;

`ifdef TAPE_REMOTE_GATE_EN
  assign run = remote;
`else
  logic unused_remote;
  assign unused_remote = remote;
  assign run = 1'b1;
`endif

  // Body bits come from the shift register (start, data LSB first, parity); stop bits are all ones.
  assign cur_bit = in_stop_q | shr_q[0];
  assign b_end   = cur_bit ? SHORT_END : LONG_END;

  always_ff @(posedge clk_24) begin
    if (reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      rd_addr   <= '0;
      rd_req    <= 1'b0;
      tape_out  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      shr_q     <= '0;
      bit_q     <= '0;
      cnt_q     <= '0;
      phase_b_q <= 1'b0;
      in_stop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      rd_addr   <= addr_d;
      rd_req    <= req_d;
      tape_out  <= tape_d;
      busy      <= busy_d;
      done      <= done_d;
      shr_q     <= shr_d;
      bit_q     <= bit_d;
      cnt_q     <= cnt_d;
      phase_b_q <= phase_b_d;
      in_stop_q <= in_stop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    addr_d    = rd_addr;
    req_d     = rd_req;
    tape_d    = tape_out;
    busy_d    = busy;
    done_d    = 1'b0;
    shr_d     = shr_q;
    bit_d     = bit_q;
    cnt_d     = cnt_q;
    phase_b_d = phase_b_q;
    in_stop_d = in_stop_q;
    if (stop) begin
      state_d = IDLE;
      req_d   = 1'b0;
      tape_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tape_d = 1'b0;
          if (start) begin
            len_d  = tap_len;
            addr_d = '0;
            if (tap_len == '0) begin
              state_d = FINISH;
              done_d  = 1'b1;
            end else begin
              state_d = FETCH;
              busy_d  = 1'b1;
              req_d   = 1'b1;
            end
          end
        end
        FETCH: begin
          tape_d = 1'b0;
          req_d  = 1'b1;
          if (rd_ack && rd_req) begin
            req_d     = 1'b0;
            shr_d     = {~^rd_data, rd_data, 1'b0};
            bit_d     = '0;
            cnt_d     = '0;
            phase_b_d = 1'b0;
            in_stop_d = 1'b0;
            tape_d    = 1'b1;
            state_d   = SEND;
          end
        end
        SEND: begin
          if (run) begin
            if (!phase_b_q) begin
              if (cnt_q == SHORT_END) begin
                cnt_d     = '0;
                phase_b_d = 1'b1;
                tape_d    = 1'b0;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end else if (cnt_q != b_end) begin
              cnt_d = cnt_q + CNT_W'(1);
            end else begin
              // End of a bit cell: advance to the next bit or close the frame.
              cnt_d     = '0;
              phase_b_d = 1'b0;
              tape_d    = 1'b1;
              if (!in_stop_q) begin
                shr_d = shr_q >> 1;
                if (bit_q == LAST_BODY) begin
                  in_stop_d = 1'b1;
                  bit_d     = '0;
                end else begin
                  bit_d = bit_q + BIT_W'(1);
                end
              end else if (bit_q != LAST_STOP) begin
                bit_d = bit_q + BIT_W'(1);
              end else begin
                tape_d = 1'b0;
                addr_d = rd_addr + ADDR_W'(1);
                if (rd_addr == len_q - ADDR_W'(1)) begin
                  state_d = FINISH;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                end else begin
                  state_d = FETCH;
                  req_d   = 1'b1;
                end
              end
            end
          end
        end
        FINISH: begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
